// File: rtl/tdc_meas_ctrl_if.sv
// Result handshake bundle between the TDC measurement controller and the readout logic.
// The controller drives the master side. The readout logic drives res_ready on the slave side.
interface tdc_meas_ctrl_if #(
    parameter int SUM_W    = 16,
    parameter int ACC_LOG2 = 4
);
    logic                      res_valid;
    logic                      res_ready;
    logic [SUM_W+ACC_LOG2-1:0] res_sum;
    logic [8+ACC_LOG2-1:0]     res_edges;

    modport master (
        output res_valid,
        output res_sum,
        output res_edges,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_sum,
        input  res_edges,
        output res_ready
    );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement controller: gates hits into the edge encoders, collects 2^ACC_LOG2 samples
// and presents the accumulated result. Optional macro TDC_CTRL_ZERO_REJECT_EN rejects zero-edge samples.
//
//   state  | meaning
//   S_IDLE | armed; a hit with enable raises cap_en
//   S_WAIT | counting down the encoder pipeline latency
//   S_OUT  | result held on res_* until the consumer takes it
module tdc_meas_ctrl #(
    parameter int ENC_LAT  = 6,
    parameter int SUM_W    = 16,
    parameter int ACC_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             hit,
    output logic             cap_en,
    input  logic [SUM_W-1:0] enc_sum,
    input  logic [7:0]       enc_num,
    output logic             busy,
    tdc_meas_ctrl_if.master  res,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      miss_cnt
);

    localparam int RES_SUM_W  = SUM_W + ACC_LOG2;
    localparam int RES_EDGE_W = 8 + ACC_LOG2;
    localparam int CNT_W      = ACC_LOG2 + 1;

    localparam logic [7:0]       LAT_LOAD = 8'(ENC_LAT - 1);
    localparam logic [CNT_W-1:0] N_SMP    = CNT_W'(2 ** ACC_LOG2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]            lat_cnt;
    logic [RES_SUM_W-1:0]  acc_sum;
    logic [RES_EDGE_W-1:0] acc_edges;
    logic [CNT_W-1:0]      smp_cnt;
    logic [RES_SUM_W-1:0]  sum_total;
    logic [RES_EDGE_W-1:0] edges_total;
    logic [CNT_W-1:0]      smp_cnt_inc;
    logic [RES_SUM_W-1:0]  res_sum_q;
    logic [RES_EDGE_W-1:0] res_edges_q;
    logic [15:0]           drop_q;

    logic take;
    logic done;
    logic abort;
    logic drop;
`ifdef TDC_CTRL_ZERO_REJECT_EN
    logic        miss;
    logic [15:0] miss_q;
`endif

    // Totals include the sample being taken this cycle.
    assign sum_total   = acc_sum + RES_SUM_W'(enc_sum);
    assign edges_total = acc_edges + RES_EDGE_W'(enc_num);
    assign smp_cnt_inc = smp_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        take      = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        drop      = 1'b0;
`ifdef TDC_CTRL_ZERO_REJECT_EN
        miss      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (hit && enable) begin
                    cap_en    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                drop = hit && enable;
                if (!enable) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (lat_cnt == 8'd0) begin
                    state_nxt = S_IDLE;
`ifdef TDC_CTRL_ZERO_REJECT_EN
                    if (enc_num == 8'd0) begin
                        miss = 1'b1;
                    end else
`endif
                    begin
                        take = 1'b1;
                        if (smp_cnt_inc == N_SMP) begin
                            done      = 1'b1;
                            state_nxt = S_OUT;
                        end
                    end
                end
            end
            S_OUT: begin
                drop = hit && enable;
                if (res.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= 8'd0;
        end else if (cap_en) begin
            lat_cnt <= LAT_LOAD;
        end else if ((state == S_WAIT) && (lat_cnt != 8'd0)) begin
            lat_cnt <= lat_cnt - 8'd1;
        end
    end

    // Completing a result and aborting both start the next result from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum   <= '0;
            acc_edges <= '0;
            smp_cnt   <= '0;
        end else if (abort || done) begin
            acc_sum   <= '0;
            acc_edges <= '0;
            smp_cnt   <= '0;
        end else if (take) begin
            acc_sum   <= sum_total;
            acc_edges <= edges_total;
            smp_cnt   <= smp_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum_q   <= '0;
            res_edges_q <= '0;
        end else if (done) begin
            res_sum_q   <= sum_total;
            res_edges_q <= edges_total;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 16'd0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

`ifdef TDC_CTRL_ZERO_REJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= 16'd0;
        end else if (miss && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
        end
    end

    assign miss_cnt = miss_q;
`else
    assign miss_cnt = 16'd0;
`endif

    assign busy          = (state != S_IDLE);
    assign res.res_valid = (state == S_OUT);
    assign res.res_sum   = res_sum_q;
    assign res.res_edges = res_edges_q;
    assign drop_cnt      = drop_q;

endmodule
